// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared types, defaults and helpers for prescaled_counter_bank and tick_prescaler.
//   cnt_dir_e  : per-channel count direction (CNT_UP = 0, CNT_DOWN = 1)
//   LED_*_DEF  : default LED tap position/width
//   pre_width(): bit width of the prescaler phase counter for a given PRESCALE
package counter_pkg;

    typedef enum logic {
        CNT_UP   = 1'b0,
        CNT_DOWN = 1'b1
    } cnt_dir_e;

    localparam int unsigned LED_LSB_DEF  = 2;
    localparam int unsigned LED_BITS_DEF = 4;

    // Wide enough to hold PRESCALE-1; never narrower than one bit.
    function automatic int unsigned pre_width(input int unsigned prescale);
        return $clog2(prescale + 1);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler
//   Divides enabled clock cycles by PRESCALE and emits a registered one-cycle tick.
//   Phase counter runs 0..PRESCALE-1 while en=1 and is frozen (not cleared) while en=0.
// Ports
//   clk   in   clock, posedge
//   rst   in   synchronous active-high reset; clears phase and tick
//   en    in   global enable
//   tick  out  high for the cycle after the phase counter wraps with en=1
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned       PW       = pre_width(PRESCALE);
    localparam logic [PW-1:0]     PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_pre;
    logic          r_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre  <= '0;
            r_tick <= 1'b0;
        end else if (en) begin
            if (r_pre == PRE_LAST) begin
                r_pre  <= '0;
                r_tick <= 1'b1;
            end else begin
                r_pre  <= r_pre + 1'b1;
                r_tick <= 1'b0;
            end
        end else begin
            // Phase is held so the period resumes where it left off.
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/prescaled_counter_bank.sv
// prescaled_counter_bank
//   CHANNELS independent WIDTH-bit counters stepped by one shared prescaler tick.
//   Per channel: enable, direction, parallel load (highest priority), wrap or
//   saturate at bounds, one-cycle terminal-count pulse and an LED tap of the count.
// Ports
//   clk       in   clock, posedge
//   rst       in   synchronous active-high reset
//   en        in   global enable for prescaler (and therefore all steps)
//   ch_en     in   per-channel step enable
//   ch_dir    in   per-channel direction, 0 up / 1 down
//   load      in   per-channel load strobe
//   load_val  in   load values, channel i at [i*WIDTH +: WIDTH]
//   tick      out  registered prescaler tick
//   count     out  counts, same packing as load_val
//   tc        out  per-channel terminal-count pulse
//   io_led    out  count[i][LED_LSB +: LED_BITS] per channel
module prescaled_counter_bank
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned SATURATE = 0,
    parameter int unsigned LED_LSB  = LED_LSB_DEF,
    parameter int unsigned LED_BITS = LED_BITS_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [CHANNELS-1:0]          ch_en,
    input  logic [CHANNELS-1:0]          ch_dir,
    input  logic [CHANNELS-1:0]          load,
    input  logic [CHANNELS*WIDTH-1:0]    load_val,
    output logic                         tick,
    output logic [CHANNELS*WIDTH-1:0]    count,
    output logic [CHANNELS-1:0]          tc,
    output logic [CHANNELS*LED_BITS-1:0] io_led
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam bit               SAT     = (SATURATE != 0);

    logic w_tick;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (w_tick)
    );

    assign tick = w_tick;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [WIDTH-1:0] r_cnt;
        logic [WIDTH-1:0] w_cnt_d;
        logic             r_tc;
        logic             w_tc_d;
        cnt_dir_e         w_dir;

        assign w_dir = cnt_dir_e'(ch_dir[gi]);

        always_comb begin
            w_cnt_d = r_cnt;
            w_tc_d  = 1'b0;
            if (load[gi]) begin
                // Load overrides any coincident step, including a wrapping one.
                w_cnt_d = load_val[gi*WIDTH +: WIDTH];
            end else if (w_tick && ch_en[gi]) begin
                if (w_dir == CNT_UP) begin
                    if (r_cnt == CNT_MAX) begin
                        // At the bound: wrap with tc, or hold silently when saturating.
                        if (!SAT) begin
                            w_cnt_d = '0;
                            w_tc_d  = 1'b1;
                        end
                    end else begin
                        w_cnt_d = r_cnt + CNT_ONE;
                        w_tc_d  = SAT && (r_cnt == CNT_MAX - CNT_ONE);
                    end
                end else begin
                    if (r_cnt == '0) begin
                        if (!SAT) begin
                            w_cnt_d = CNT_MAX;
                            w_tc_d  = 1'b1;
                        end
                    end else begin
                        w_cnt_d = r_cnt - CNT_ONE;
                        w_tc_d  = SAT && (r_cnt == CNT_ONE);
                    end
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
                r_tc  <= 1'b0;
            end else begin
                r_cnt <= w_cnt_d;
                r_tc  <= w_tc_d;
            end
        end

        assign count[gi*WIDTH +: WIDTH]        = r_cnt;
        assign tc[gi]                          = r_tc;
        assign io_led[gi*LED_BITS +: LED_BITS] = r_cnt[LED_LSB +: LED_BITS];
    end

endmodule

// File: tb/tb_prescaled_counter_bank.sv
// Bench for prescaled_counter_bank.
//   dut_a: WIDTH=8, CHANNELS=4, PRESCALE=4, wrap mode.
//   dut_b: WIDTH=8, CHANNELS=2, PRESCALE=1, saturate mode.
// Stimulus pushes hand-computed expectations tagged with the cycle they apply to;
// a negedge monitor pops and compares the entries due in the current cycle.
module tb_prescaled_counter_bank;

    localparam int F_COUNT = 0;
    localparam int F_TC    = 1;
    localparam int F_TICK  = 2;
    localparam int F_LED   = 3;

    typedef struct {
        int unsigned cyc;
        string       tag;
        bit          dut_b;
        int          fld;
        int          idx;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // dut_a signals
    logic        rst_a = 1'b1;
    logic        en_a  = 1'b1;
    logic [3:0]  ch_en_a = '0;
    logic [3:0]  dir_a   = '0;
    logic [3:0]  load_a  = '0;
    logic [31:0] lv_a    = '0;
    logic        tick_a;
    logic [31:0] count_a;
    logic [3:0]  tc_a;
    logic [15:0] led_a;

    // dut_b signals
    logic        rst_b = 1'b1;
    logic        en_b  = 1'b1;
    logic [1:0]  ch_en_b = '0;
    logic [1:0]  dir_b   = '0;
    logic [1:0]  load_b  = '0;
    logic [15:0] lv_b    = '0;
    logic        tick_b;
    logic [15:0] count_b;
    logic [1:0]  tc_b;
    logic [7:0]  led_b;

    prescaled_counter_bank #(
        .WIDTH(8), .CHANNELS(4), .PRESCALE(4), .SATURATE(0), .LED_LSB(2), .LED_BITS(4)
    ) dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .ch_en(ch_en_a), .ch_dir(dir_a),
        .load(load_a), .load_val(lv_a), .tick(tick_a), .count(count_a), .tc(tc_a),
        .io_led(led_a)
    );

    prescaled_counter_bank #(
        .WIDTH(8), .CHANNELS(2), .PRESCALE(1), .SATURATE(1), .LED_LSB(2), .LED_BITS(4)
    ) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .ch_en(ch_en_b), .ch_dir(dir_b),
        .load(load_b), .load_val(lv_b), .tick(tick_b), .count(count_b), .tc(tc_b),
        .io_led(led_b)
    );

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic ex(input int unsigned at, input string tag, input bit b, input int fld,
                      input int idx, input logic [31:0] v);
        exp_t e;
        e.cyc   = at;
        e.tag   = tag;
        e.dut_b = b;
        e.fld   = fld;
        e.idx   = idx;
        e.val   = v;
        q.push_back(e);
    endtask

    function automatic logic [31:0] actual(input exp_t e);
        logic [31:0] r;
        r = '0;
        if (!e.dut_b) begin
            case (e.fld)
                F_COUNT: r = 32'(count_a[e.idx*8 +: 8]);
                F_TC:    r = 32'(tc_a);
                F_TICK:  r = 32'(tick_a);
                F_LED:   r = 32'(led_a);
                default: r = '1;
            endcase
        end else begin
            case (e.fld)
                F_COUNT: r = 32'(count_b[e.idx*8 +: 8]);
                F_TC:    r = 32'(tc_b);
                F_TICK:  r = 32'(tick_b);
                F_LED:   r = 32'(led_b);
                default: r = '1;
            endcase
        end
        return r;
    endfunction

    // Monitor: compare every expectation due in this cycle.
    always @(negedge clk) begin
        logic [31:0] act;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                act   = actual(q[i]);
                total = total + 1;
                if (act !== q[i].val) begin
                    bad = bad + 1;
                    $display("FAIL %s cyc=%0d got=%0h want=%0h", q[i].tag, cyc, act, q[i].val);
                end
                q.delete(i);
            end
        end
    end

    task automatic wait_until(input int unsigned c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n;

        // Reset: both DUTs held in reset with en=1.
        for (int c = 1; c <= 2; c++) begin
            ex(c, "rst_a_cnt0", 0, F_COUNT, 0, 0);
            ex(c, "rst_a_tick", 0, F_TICK, 0, 0);
            ex(c, "rst_a_tc",   0, F_TC, 0, 0);
            ex(c, "rst_a_led",  0, F_LED, 0, 0);
            ex(c, "rst_b_tick", 1, F_TICK, 0, 0);
            ex(c, "rst_b_cnt0", 1, F_COUNT, 0, 0);
        end
        wait_until(2);

        // Count: ch0/ch1 up, ch2 disabled, ch3 down (wraps from 0 on the first step).
        rst_a   = 1'b0;
        ch_en_a = 4'b1011;
        dir_a   = 4'b1000;
        for (int c = 3; c <= 43; c++) begin
            n = (c - 3) / 4;
            ex(c, "cnt_a_ch0",  0, F_COUNT, 0, n);
            ex(c, "cnt_a_ch1",  0, F_COUNT, 1, n);
            ex(c, "cnt_a_ch3",  0, F_COUNT, 3, (256 - n) % 256);
            ex(c, "cnt_a_tick", 0, F_TICK, 0, (c >= 6 && (c - 2) % 4 == 0) ? 1 : 0);
            ex(c, "cnt_a_tc",   0, F_TC, 0, (c == 7) ? 8 : 0);
        end
        ex(43, "cnt_a_ch2", 0, F_COUNT, 2, 0);
        ex(43, "cnt_a_led", 0, F_LED, 0, 32'h0000_D022);
        wait_until(43);

        // en low for 5 edges mid-period: phase frozen at 1, next tick delayed by 5.
        en_a = 1'b0;
        for (int c = 44; c <= 52; c++) begin
            ex(c, "frz_tick", 0, F_TICK, 0, (c == 51) ? 1 : 0);
            ex(c, "frz_cnt0", 0, F_COUNT, 0, (c == 52) ? 11 : 10);
        end
        wait_until(48);
        en_a = 1'b1;
        wait_until(52);

        // Wrap: load ch1 with FE, then FF, then 00 with a one-cycle tc.
        load_a = 4'b0010;
        lv_a   = 32'h0000_FE00;
        ex(53, "wrap_load",   0, F_COUNT, 1, 8'hFE);
        ex(53, "wrap_tc53",   0, F_TC, 0, 0);
        ex(56, "wrap_ff",     0, F_COUNT, 1, 8'hFF);
        ex(56, "wrap_tc56",   0, F_TC, 0, 0);
        ex(60, "wrap_00",     0, F_COUNT, 1, 8'h00);
        ex(60, "wrap_tc60",   0, F_TC, 0, 4'b0010);
        ex(61, "wrap_tc61",   0, F_TC, 0, 0);
        ex(60, "wrap_cnt0",   0, F_COUNT, 0, 13);
        wait_until(53);
        load_a = 4'b0000;

        // Load coincident with a wrapping step: load wins, no tc.
        wait_until(61);
        load_a = 4'b0010;
        lv_a   = 32'h0000_FF00;
        ex(62, "ld_max", 0, F_COUNT, 1, 8'hFF);
        wait_until(62);
        load_a = 4'b0000;
        wait_until(63);
        load_a = 4'b0010;
        lv_a   = 32'h0000_5500;
        ex(64, "ldtick_cnt1", 0, F_COUNT, 1, 8'h55);
        ex(64, "ldtick_tc",   0, F_TC, 0, 0);
        ex(64, "ldtick_cnt0", 0, F_COUNT, 0, 14);
        wait_until(64);
        load_a = 4'b0000;

        // Mid-run reset clears everything and restarts the prescaler phase.
        wait_until(65);
        rst_a = 1'b1;
        ex(66, "mrst_cnt0", 0, F_COUNT, 0, 0);
        ex(66, "mrst_cnt1", 0, F_COUNT, 1, 0);
        ex(66, "mrst_cnt3", 0, F_COUNT, 3, 0);
        ex(66, "mrst_tick", 0, F_TICK, 0, 0);
        ex(66, "mrst_tc",   0, F_TC, 0, 0);
        ex(66, "mrst_led",  0, F_LED, 0, 0);
        wait_until(66);
        rst_a = 1'b0;
        for (int c = 67; c <= 70; c++) ex(c, "mrst_phase", 0, F_TICK, 0, (c == 70) ? 1 : 0);
        ex(71, "mrst_cnt0_after", 0, F_COUNT, 0, 1);
        ex(71, "mrst_cnt3_after", 0, F_COUNT, 3, 8'hFF);
        ex(71, "mrst_tc_after",   0, F_TC, 0, 4'b1000);
        wait_until(72);

        // Saturate (dut_b, PRESCALE=1): ch0 down from 1, ch1 up from FE.
        rst_b   = 1'b0;
        en_b    = 1'b0;
        load_b  = 2'b11;
        lv_b    = 16'hFE01;
        ch_en_b = 2'b11;
        dir_b   = 2'b01;
        ex(73, "sat_ld0",   1, F_COUNT, 0, 1);
        ex(73, "sat_ld1",   1, F_COUNT, 1, 8'hFE);
        ex(73, "sat_tick0", 1, F_TICK, 0, 0);
        wait_until(73);
        load_b = 2'b00;
        en_b   = 1'b1;
        ex(74, "sat_tick74", 1, F_TICK, 0, 1);
        ex(74, "sat_cnt0_74", 1, F_COUNT, 0, 1);
        ex(74, "sat_cnt1_74", 1, F_COUNT, 1, 8'hFE);
        ex(75, "sat_cnt0_75", 1, F_COUNT, 0, 0);
        ex(75, "sat_cnt1_75", 1, F_COUNT, 1, 8'hFF);
        ex(75, "sat_tc75",    1, F_TC, 0, 2'b11);
        ex(76, "sat_cnt0_76", 1, F_COUNT, 0, 0);
        ex(76, "sat_cnt1_76", 1, F_COUNT, 1, 8'hFF);
        ex(76, "sat_tc76",    1, F_TC, 0, 0);
        ex(77, "sat_cnt0_77", 1, F_COUNT, 0, 0);
        ex(77, "sat_tc77",    1, F_TC, 0, 0);
        wait_until(77);
        en_b = 1'b0;
        ex(78, "sat_tick78", 1, F_TICK, 0, 0);
        ex(78, "sat_tc78",   1, F_TC, 0, 0);
        wait_until(78);
        en_b = 1'b1;
        ex(79, "sat_tick79", 1, F_TICK, 0, 1);

        wait_until(82);
        total = total + 1;
        if (q.size() != 0) begin
            bad = bad + 1;
            $display("FAIL scoreboard_drain got=%0d pending want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
